// File: rtl/mac_accumulator_if.sv
// Operand-in / result-out handshake bundle for the MAC accumulator.
// master = producer/consumer side, slave = accumulator side.
interface mac_accumulator_if #(
  parameter int ACC_W = 19
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_x;
  logic [7:0]       in_y;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/mac_accumulator.sv
// Unsigned 8x8 multiply-accumulate of N_TERMS pairs; result valid 2 cycles after last accept.
// Input stalls once N_TERMS pairs are taken until the result is consumed; result held under out_ready=0.
module mac_accumulator #(
  parameter int ACC_W   = 19,
  parameter int N_TERMS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  mac_accumulator_if.slave  bus
);

  localparam int              CNT_W  = 8;
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_TERMS);

  typedef enum logic {RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       y_q, y_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             s1_vld_q, s1_vld_d;
  logic             ovf_q, ovf_d;
  logic             out_vld_q, out_vld_d;

  logic [15:0]      prod;
  logic [ACC_W:0]   acc_sum;
  logic             accept;

  assign prod    = {8'b0, x_q} * {8'b0, y_q};
  // Extra top bit captures the carry that marks a wrap of the accumulator.
  assign acc_sum = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, prod};

  assign bus.in_ready  = rst_n && (state_q == RUN) && !clear && (in_cnt_q < N_LAST);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_vld_q;
  assign bus.out_sum   = (state_q == DONE) ? acc_q : '0;
  assign bus.out_ovf   = ovf_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    in_cnt_d  = in_cnt_q;
    acc_cnt_d = acc_cnt_q;
    s1_vld_d  = accept;
    ovf_d     = ovf_q;
    out_vld_d = out_vld_q;

    if (accept) begin
      x_d      = bus.in_x;
      y_d      = bus.in_y;
      in_cnt_d = in_cnt_q + 1'b1;
    end

    if (s1_vld_q) begin
      acc_d     = acc_sum[ACC_W-1:0];
      acc_cnt_d = acc_cnt_q + 1'b1;
      if (acc_sum[ACC_W]) ovf_d = 1'b1;
      if (acc_cnt_d == N_LAST) begin
        state_d   = DONE;
        out_vld_d = 1'b1;
      end
    end

    if ((state_q == DONE) && out_vld_q && bus.out_ready) begin
      acc_d     = '0;
      in_cnt_d  = '0;
      acc_cnt_d = '0;
      ovf_d     = 1'b0;
      out_vld_d = 1'b0;
      state_d   = RUN;
    end

    // Frame abort wins over everything, including an in-flight product.
    if (clear) begin
      acc_d     = '0;
      in_cnt_d  = '0;
      acc_cnt_d = '0;
      s1_vld_d  = 1'b0;
      ovf_d     = 1'b0;
      out_vld_d = 1'b0;
      state_d   = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      in_cnt_q  <= '0;
      acc_cnt_q <= '0;
      s1_vld_q  <= 1'b0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      acc_q     <= acc_d;
      in_cnt_q  <= in_cnt_d;
      acc_cnt_q <= acc_cnt_d;
      s1_vld_q  <= s1_vld_d;
      ovf_q     <= ovf_d;
      out_vld_q <= out_vld_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench: default instance (19b, 8 terms) and a narrow instance (16b, 2 terms).
module tb_mac_accumulator;

  logic clk;
  logic rst_n;
  logic clear;

  mac_accumulator_if #(.ACC_W(19)) a ();
  mac_accumulator_if #(.ACC_W(16)) b ();

  mac_accumulator #(.ACC_W(19), .N_TERMS(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (a.slave)
  );

  mac_accumulator #(.ACC_W(16), .N_TERMS(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (b.slave)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_pass  = 0;
  int   n_total = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic send_a(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    a.in_valid = 1'b1; a.in_x = x; a.in_y = y;
    @(negedge clk);
    while (!a.in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      n_total++;
      $display("FAIL a_send_timeout: in_ready stuck at 0, expected 1");
    end
    @(posedge clk); #1;
    a.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    b.in_valid = 1'b1; b.in_x = x; b.in_y = y;
    @(negedge clk);
    while (!b.in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      n_total++;
      $display("FAIL b_send_timeout: in_ready stuck at 0, expected 1");
    end
    @(posedge clk); #1;
    b.in_valid = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (qa.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("a_result_drained", qa.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while (qb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("b_result_drained", qb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic push_a(input logic [31:0] s, input logic o);
    exp_t e;
    e.sum = s; e.ovf = o;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] s, input logic o);
    exp_t e;
    e.sum = s; e.ovf = o;
    qb.push_back(e);
  endtask

  // Result monitors: compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && a.out_valid && a.out_ready) begin
      if (qa.size() == 0) begin
        n_total++;
        $display("FAIL a_unexpected_result: got sum %0d, expected no result", a.out_sum);
      end else begin
        ea = qa.pop_front();
        chk("a_sum", 32'(a.out_sum), ea.sum);
        chk("a_ovf", 32'(a.out_ovf), 32'(ea.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b.out_valid && b.out_ready) begin
      if (qb.size() == 0) begin
        n_total++;
        $display("FAIL b_unexpected_result: got sum %0d, expected no result", b.out_sum);
      end else begin
        eb = qb.pop_front();
        chk("b_sum", 32'(b.out_sum), eb.sum);
        chk("b_ovf", 32'(b.out_ovf), 32'(eb.ovf));
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; clear = 1'b0;
    a.in_valid = 1'b0; a.in_x = '0; a.in_y = '0; a.out_ready = 1'b1;
    b.in_valid = 1'b0; b.in_x = '0; b.in_y = '0; b.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(a.out_valid), 0);
    chk("rst_out_sum",   32'(a.out_sum),   0);
    chk("rst_in_ready",  32'(a.in_ready),  0);
    chk("rst_out_ovf",   32'(a.out_ovf),   0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(a.in_ready), 1);
    @(posedge clk); #1;

    // Reset mid-frame discards partial data
    for (int i = 0; i < 3; i++) send_a(8'd1, 8'd1);
    rst_n = 1'b0; #1;
    chk("midrst_out_valid", 32'(a.out_valid), 0);
    chk("midrst_out_sum",   32'(a.out_sum),   0);
    chk("midrst_out_ovf",   32'(a.out_ovf),   0);
    chk("midrst_in_ready",  32'(a.in_ready),  0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_in_ready", 32'(a.in_ready), 1);
    @(posedge clk); #1;
    push_a(8, 1'b0);
    for (int i = 0; i < 8; i++) send_a(8'd1, 8'd1);
    wait_idle_a();

    // Back-to-back (k,k+1): latency and in_ready profile
    push_a(240, 1'b0);
    for (int k = 1; k <= 8; k++) send_a(8'(k), 8'(k + 1));
    @(negedge clk);
    chk("lat_k1_out_valid", 32'(a.out_valid), 0);
    chk("lat_k1_in_ready",  32'(a.in_ready),  0);
    @(negedge clk);
    chk("lat_k2_out_valid", 32'(a.out_valid), 1);
    chk("lat_k2_in_ready",  32'(a.in_ready),  0);
    @(negedge clk);
    chk("post_hs_out_valid", 32'(a.out_valid), 0);
    chk("post_hs_out_sum",   32'(a.out_sum),   0);
    chk("post_hs_in_ready",  32'(a.in_ready),  1);
    @(posedge clk); #1;
    wait_idle_a();

    // Max operands with random gaps
    push_a(520200, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_a(8'd255, 8'd255);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_idle_a();

    // Backpressure in DONE
    a.out_ready = 1'b0;
    push_a(800, 1'b0);
    for (int i = 0; i < 8; i++) send_a(8'd10, 8'd10);
    n = 0;
    @(negedge clk);
    while (!a.out_valid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(a.out_valid), 1);
      chk("bp_out_sum",   32'(a.out_sum),   800);
      chk("bp_in_ready",  32'(a.in_ready),  0);
      @(negedge clk);
    end
    @(posedge clk); #1; a.out_ready = 1'b1;
    wait_idle_a();
    push_a(32, 1'b0);
    for (int i = 0; i < 8; i++) send_a(8'd2, 8'd2);
    wait_idle_a();

    // clear with a product still in stage 1
    for (int i = 0; i < 3; i++) send_a(8'd5, 8'd5);
    clear = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", 32'(a.in_ready), 0);
    @(posedge clk); #1; clear = 1'b0;
    @(negedge clk);
    chk("clr_after_in_ready",  32'(a.in_ready),  1);
    chk("clr_after_out_valid", 32'(a.out_valid), 0);
    @(posedge clk); #1;
    push_a(24, 1'b0);
    for (int i = 0; i < 8; i++) send_a(8'd3, 8'd1);
    wait_idle_a();

    // Narrow accumulator wraps, then next frame starts clean
    push_b(64514, 1'b1);
    send_b(8'd255, 8'd255);
    send_b(8'd255, 8'd255);
    wait_idle_b();
    push_b(2, 1'b0);
    send_b(8'd1, 8'd1);
    send_b(8'd1, 8'd1);
    wait_idle_b();

    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Sequential multiply-accumulate stage for the team's unsigned 8x8 combinational multiplier.
- Accepts a stream of 8-bit operand pairs over a valid/ready handshake and registers them in front of the multiplier.
- Sums N_TERMS consecutive 16-bit products into one accumulator result.
- Presents each result on a valid/ready output with a sticky overflow flag (dot-product / FIR-tap style use).

Parameters:
- ACC_W, 19, accumulator and out_sum width; legal range 16..32. The default exactly holds 8 x 255 x 255 = 520200.
- N_TERMS, 8, number of products summed per result; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous assert, active-low
- clear  input  1  synchronous frame abort, active-high
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair this cycle
- in_x  input  8  unsigned operand X
- in_y  input  8  unsigned operand Y
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  ACC_W  accumulated sum of products
- out_ovf  output  1  sticky: accumulator wrapped during this frame

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN; x_r, y_r, acc, in_cnt, acc_cnt, s1_valid and out_ovf all 0.
  - Outputs: out_valid=0, out_sum=0, in_ready=0 while reset is held.
  - Reset mid-frame discards all partial data.
- States: RUN (accepting/accumulating) and DONE (result held).
- in_ready = (state==RUN) && !clear && (in_cnt < N_TERMS). Combinational from registers and clear only; never depends on in_valid.
- Accept = in_valid && in_ready:
  - Stage 1: x_r<=in_x, y_r<=in_y, s1_valid<=1, in_cnt++.
  - No accept: s1_valid<=0, x_r/y_r hold.
- Multiply: p = x_r*y_r, 16-bit unsigned and bit-exact. Either instantiate the team multiplier or use an equivalent.
- Stage 2 (s1_valid=1):
  - acc <= acc + zero-extended p, modulo 2^ACC_W; acc_cnt++.
  - Carry out of bit ACC_W-1 sets out_ovf (sticky within the frame).
- Transition to DONE:
  - When a stage-2 update makes acc_cnt==N_TERMS, the next state is DONE and out_valid<=1.
  - out_sum = acc (registered) and includes the final product.
- Latency: last operand accepted in cycle k gives out_valid=1 in cycle k+2.
- Throughput: one pair per cycle, with in_valid gaps allowed. in_ready drops the cycle after the N_TERMS-th accept and stays low through DONE.
- DONE:
  - out_valid, out_sum and out_ovf are held stable until out_ready=1.
  - On out_valid && out_ready: acc, in_cnt, acc_cnt and out_ovf are zeroed; out_valid<=0; state<=RUN.
  - in_ready=1 the following cycle; no same-cycle accept on the handshake cycle.
- clear=1:
  - Priority over all activity except reset; applies in any state.
  - Next edge: acc, in_cnt, acc_cnt, s1_valid and out_ovf are 0; out_valid=0; state=RUN.
  - The stage-1 product in flight is dropped. A pending unconsumed result is discarded.
- out_sum is 0 whenever out_valid=0, except that it holds the result during DONE.
- N_TERMS=1: each accepted pair yields a result 2 cycles later; in_ready is low until that result is consumed.

Test Plan:
- Reset mid-frame: rst_n low for 2 cycles after 3 accepts -> out_valid=0, out_sum=0, out_ovf=0 immediately. After release, in_ready=1, and a fresh 8 pairs of (1,1) give out_sum=8.
- Defaults, pairs (k,k+1) for k=1..8 back-to-back, out_ready=1 -> out_valid at 2 cycles after the 8th accept, out_sum=240, out_ovf=0. in_ready=0 from the cycle after the 8th accept until the cycle after the handshake.
- Max values: 8 pairs of (255,255) with random in_valid gaps -> out_sum=520200, out_ovf=0.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_sum and in_ready=0 all held. Then handshake, then 8 pairs of (2,2) -> out_sum=32 (accumulator was cleared).
- Overflow (ACC_W=16, N_TERMS=2): pairs (255,255),(255,255) -> out_sum=64514, out_ovf=1. Next frame (1,1),(1,1) -> out_sum=2, out_ovf=0.
- clear asserted one cycle after the 3rd accept (product still in stage 1) -> in_ready=0 that cycle and the partial frame is discarded. Next 8 pairs of (3,1) -> out_sum=24.
